// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: reads a raster frame from a 1-cycle-latency frame
// buffer, streams it into conv through a 2-entry skid FIFO, and counts conv
// output beats until the full output map is collected.
module conv_frame_sequencer #(
  parameter int IMG_W   = 32,
  parameter int IMG_H   = 32,
  parameter int K       = 5,
  parameter int TIMEOUT = 4096,
  parameter int ADDR_W  = $clog2(IMG_W*IMG_H)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [7:0]        i_rd_data,
  output logic              o_feature_valid,
  output logic [7:0]        o_feature,
  input  logic              i_ready_feature,
  input  logic              i_conv_valid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err_timeout,
  output logic              o_err_overflow,
  output logic [15:0]       o_frame_count
);
  localparam int NPIX  = IMG_W*IMG_H;
  localparam int OUT_N = (IMG_H-K+1)*(IMG_W-K+1);
  localparam int PW    = $clog2(NPIX+1);
  localparam int OW    = $clog2(OUT_N+1);
  localparam int TW    = $clog2(TIMEOUT+1);
  localparam logic [PW-1:0] NPIX_C  = PW'(NPIX);
  localparam logic [PW-1:0] LAST_C  = PW'(NPIX-1);
  localparam logic [OW-1:0] OUTN_C  = OW'(OUT_N);
  localparam logic [OW-1:0] OUTN1_C = OW'(OUT_N-1);
  localparam logic [TW-1:0] TMO_C   = TW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t        state, state_n;
  logic [PW-1:0] rd_addr, pix_cnt;
  logic [OW-1:0] out_cnt;
  logic [TW-1:0] idle_cnt, idle_nxt;
  logic [1:0]    fifo_cnt;
  logic [7:0]    e0, e1;
  logic          inflight;
  logic          err_to, err_ov;
  logic [15:0]   frame_cnt;
  logic          pop, counting, beat_ok, beat_ovf, hit, accept, tmo;
  logic [2:0]    occ;

  // Datapath strobes; a read returning this cycle bypasses into the head when the FIFO is empty
  always_comb begin
    o_feature_valid = (fifo_cnt != 2'd0) | inflight;
    o_feature       = (fifo_cnt != 2'd0) ? e0 : (inflight ? i_rd_data : 8'h00);
    pop             = o_feature_valid & i_ready_feature;
    occ             = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, pop};
    o_rd_en         = (state == S_STREAM) && (rd_addr < NPIX_C) && (occ < 3'd2) && !i_abort;
    o_rd_addr       = rd_addr[ADDR_W-1:0];
    counting        = ((state == S_STREAM) || (state == S_DRAIN)) && i_conv_valid;
    beat_ok         = counting && (out_cnt != OUTN_C);
    beat_ovf        = counting && (out_cnt == OUTN_C);
    hit             = beat_ok && (out_cnt == OUTN1_C);
    idle_nxt        = idle_cnt + TW'(1);
    o_busy          = (state == S_STREAM) || (state == S_DRAIN);
    o_done          = (state == S_DONE);
    o_err_timeout   = err_to;
    o_err_overflow  = err_ov;
    o_frame_count   = frame_cnt;
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      S_IDLE:   if (i_start) begin state_n = S_STREAM; accept = 1'b1; end
      S_STREAM: if (pop && (pix_cnt == LAST_C)) state_n = S_DRAIN;
      S_DRAIN: begin
        if ((out_cnt == OUTN_C) || hit) state_n = S_DONE;
        else if (!i_conv_valid && (idle_nxt == TMO_C)) begin
          state_n = S_IDLE;
          tmo     = 1'b1;
        end
      end
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
    if (i_abort) begin
      state_n = S_IDLE;
      accept  = 1'b0;
      tmo     = 1'b0;
    end
  end

  // State register, counters, skid FIFO and sticky flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      rd_addr   <= '0;
      pix_cnt   <= '0;
      out_cnt   <= '0;
      idle_cnt  <= '0;
      fifo_cnt  <= 2'd0;
      e0        <= 8'h00;
      e1        <= 8'h00;
      inflight  <= 1'b0;
      err_to    <= 1'b0;
      err_ov    <= 1'b0;
      frame_cnt <= 16'h0;
    end else begin
      state <= state_n;
      if (accept) begin
        rd_addr  <= '0;
        pix_cnt  <= '0;
        out_cnt  <= '0;
        idle_cnt <= '0;
        fifo_cnt <= 2'd0;
        inflight <= 1'b0;
        err_to   <= 1'b0;
        err_ov   <= 1'b0;
      end else if (i_abort) begin
        fifo_cnt <= 2'd0;
        inflight <= 1'b0;
      end else begin
        inflight <= o_rd_en;
        if (o_rd_en) rd_addr <= rd_addr + PW'(1);
        if (pop)     pix_cnt <= pix_cnt + PW'(1);
        unique case ({inflight, pop})
          2'b10: begin
            if (fifo_cnt == 2'd0) e0 <= i_rd_data;
            else                  e1 <= i_rd_data;
            fifo_cnt <= fifo_cnt + 2'd1;
          end
          2'b01: begin
            e0       <= e1;
            fifo_cnt <= fifo_cnt - 2'd1;
          end
          2'b11: begin
            // empty: data bypassed straight out; one entry: refill head
            if (fifo_cnt == 2'd1) e0 <= i_rd_data;
            else if (fifo_cnt == 2'd2) begin
              e0 <= e1;
              e1 <= i_rd_data;
            end
          end
          default: ;
        endcase
        if (beat_ok) out_cnt <= out_cnt + OW'(1);
        if (beat_ovf || (hit && (state == S_STREAM))) err_ov <= 1'b1;
        if (state == S_DRAIN) idle_cnt <= i_conv_valid ? '0 : idle_nxt;
        else                  idle_cnt <= '0;
        if (tmo) err_to <= 1'b1;
        if (state == S_DONE) frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
endmodule
